// File: rtl/ff_stim_gen_if.sv
// ---------------------------------------------------------------------------
// ff_stim_gen_if
// Control/stimulus bundle between ff_stim_gen and whatever drives it.
//   en   : run enable, sampled on rising reference-clock edges
//   mode : pattern select, 0 = PRBS-7, 1 = alternating 1,0,1,0...
//   cko  : divided clock for the flip-flop's CK pin
//   dout : data for the flip-flop's D pin (named dout because 'do' is a keyword)
// The master modport is the controller side; the slave modport is the generator.
// ---------------------------------------------------------------------------
interface ff_stim_gen_if;
  logic en;
  logic mode;
  logic cko;
  logic dout;

  modport master (
    output en,
    output mode,
    input  cko,
    input  dout
  );

  modport slave (
    input  en,
    input  mode,
    output cko,
    output dout
  );
endinterface

// File: rtl/ff_stim_gen.sv
// ---------------------------------------------------------------------------
// ff_stim_gen
// Stimulus source for a flip-flop cell under test. Divides the reference
// clock by DIV to produce cko (50% duty) and launches one data bit on every
// cko rising edge, so the flip-flop (capturing on cko falling edges) sees
// half a cko period of setup margin.
//
// Parameters
//   DIV  : reference edges per cko period; even, 2..32. Odd values round
//          down, out-of-range values clamp to the nearest legal value.
//   SEED : LFSR value loaded by reset; 7'h00 would lock the LFSR, so it is
//          replaced by 7'h7F.
//
// Ports
//   clk   : reference clock (CK); everything advances on its rising edge
//   rst_n : asynchronous active-low reset (RN)
//   bus   : ff_stim_gen_if.slave -- en, mode in; cko, dout out
//
// The analog output drivers (finite drive resistance into a load
// capacitance, levels tracking VDD) belong to the behavioural wrapper around
// this block; here cko and dout are the logical targets of those drivers.
// ---------------------------------------------------------------------------
module ff_stim_gen #(
  parameter int         DIV  = 4,
  parameter logic [6:0] SEED = 7'h7F
) (
  input  logic          clk,
  input  logic          rst_n,
  ff_stim_gen_if.slave  bus
);

  // Half period in reference edges; cnt counts 0..HALF-1 between ck_i toggles.
  localparam int HALF = (DIV < 2) ? 1 : ((DIV > 32) ? 16 : (DIV / 2));
  localparam logic [3:0] LAST = 4'(HALF - 1);
  localparam logic [6:0] SEED_EFF = (SEED == 7'h00) ? 7'h7F : SEED;

  logic [3:0] cnt_q,  cnt_d;
  logic       ck_i_q, ck_i_d;
  logic [6:0] lfsr_q, lfsr_d;
  logic       d_i_q,  d_i_d;

  always_comb begin
    cnt_d  = cnt_q;
    ck_i_d = ck_i_q;
    lfsr_d = lfsr_q;
    d_i_d  = d_i_q;

    // With en low every piece of state holds, so a resumed run continues
    // from the partial count rather than restarting the half period.
    if (bus.en) begin
      if (cnt_q == LAST) begin
        cnt_d  = '0;
        ck_i_d = ~ck_i_q;
        // ck_i is about to rise: launch the next data bit in the same edge,
        // so dout changes together with cko and never near the capture edge.
        if (!ck_i_q) begin
          if (bus.mode) begin
            d_i_d = ~d_i_q;
          end else begin
            // x^7 + x^6 + 1; the output bit is the new MSB, i.e. old bit 5.
            lfsr_d = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
            d_i_d  = lfsr_q[5];
          end
        end
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  // Reset clears the partial count, so the first cko rise after release
  // always lands on reference edge HALF. A clock edge coincident with the
  // release falls inside the flops' recovery window and is not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      ck_i_q <= 1'b0;
      lfsr_q <= SEED_EFF;
      d_i_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      ck_i_q <= ck_i_d;
      lfsr_q <= lfsr_d;
      d_i_q  <= d_i_d;
    end
  end

  assign bus.cko  = ck_i_q;
  assign bus.dout = d_i_q;

endmodule

// File: tb/tb_ff_stim_gen.sv
`timescale 1ns/1ps
module tb_ff_stim_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #0.5 clk = ~clk;   // 1 GHz reference

  ff_stim_gen_if bus();
  ff_stim_gen_if bus2();

  // Main instance: DIV=4, default seed.
  ff_stim_gen #(.DIV(4), .SEED(7'h7F)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Zero seed (must behave as 7'h7F) and odd DIV (7 rounds down to 6).
  ff_stim_gen #(.DIV(7), .SEED(7'h00)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic en;
    logic mode;
    logic cko;
    logic dout;
  } vec_t;

  vec_t tbl [22];

  logic exp_bits [0:299];
  logic bits     [0:299];
  logic bits2    [0:299];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_in(input logic en, input logic mode);
    bus.en   = en;
    bus.mode = mode;
    bus2.en   = en;
    bus2.mode = mode;
  endtask

  // One reference edge, then settle before sampling.
  task automatic edge_s();
    @(posedge clk);
    #0.2;
  endtask

  // Hold reset ~5 ns with the clock running, then release between edges.
  task automatic do_reset(input logic mode);
    rst_n = 1'b0;
    set_in(1'b1, mode);
    #5;
    chk("reset_cko", bus.cko, 1'b0);
    chk("reset_dout", bus.dout, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rises, rises2, edges, last_edge, last_edge2, first_edge, ones, diffs;
    logic prev, prev2, d_hold;

    // State after each edge, counted from reset release (DIV=4).
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b1};  // first rise on edge 2, PRBS bit 1
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b1};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b1};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b1};  // PRBS bit 2
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b1};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b1};  // frozen while high
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b1};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b1};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b1};  // only the remaining count
    tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b1};
    tbl[12] = '{1'b1, 1'b0, 1'b1, 1'b1};  // PRBS bit 3
    tbl[13] = '{1'b1, 1'b0, 1'b1, 1'b1};
    tbl[14] = '{1'b1, 1'b1, 1'b0, 1'b1};  // mode=1 waits for next rise
    tbl[15] = '{1'b1, 1'b1, 1'b0, 1'b1};
    tbl[16] = '{1'b1, 1'b1, 1'b1, 1'b0};  // toggle
    tbl[17] = '{1'b1, 1'b1, 1'b1, 1'b0};
    tbl[18] = '{1'b1, 1'b0, 1'b0, 1'b0};
    tbl[19] = '{1'b1, 1'b0, 1'b0, 1'b0};
    tbl[20] = '{1'b1, 1'b0, 1'b1, 1'b1};  // PRBS bit 4 from held LFSR
    tbl[21] = '{1'b1, 1'b0, 1'b1, 1'b1};

    // Expected PRBS-7 output for seed 7F: 1,1,1,1,1,1,0 then s[n]=s[n-6]^s[n-7].
    for (int n = 0; n < 6; n++) exp_bits[n] = 1'b1;
    exp_bits[6] = 1'b0;
    for (int n = 7; n < 300; n++) exp_bits[n] = exp_bits[n-6] ^ exp_bits[n-7];

    set_in(1'b1, 1'b0);
    #2;
    chk("por_cko", bus.cko, 1'b0);
    chk("por_dout", bus.dout, 1'b0);

    // ---- table-driven: divide, freeze, mode switch ----
    do_reset(1'b0);
    for (int i = 0; i < 22; i++) begin
      set_in(tbl[i].en, tbl[i].mode);
      edge_s();
      chk($sformatf("tbl%0d_cko", i), bus.cko, tbl[i].cko);
      chk($sformatf("tbl%0d_dout", i), bus.dout, tbl[i].dout);
    end

    // ---- async reset 1.3 ns after a cko rise (rise was edge 21) ----
    #0.1;
    rst_n = 1'b0;
    #0.05;
    chk("async_cko", bus.cko, 1'b0);
    chk("async_dout", bus.dout, 1'b0);
    #3;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      set_in(tbl[i].en, tbl[i].mode);
      edge_s();
      chk($sformatf("rerun%0d_cko", i), bus.cko, tbl[i].cko);
      chk($sformatf("rerun%0d_dout", i), bus.dout, tbl[i].dout);
    end

    // ---- PRBS over 254 cko cycles, plus zero-seed / DIV=7 instance ----
    do_reset(1'b0);
    rises = 0; rises2 = 0; edges = 0; last_edge = 0; last_edge2 = 0; first_edge = 0;
    prev = 1'b0; prev2 = 1'b0;
    while (rises < 254 && edges < 1100) begin
      edge_s();
      edges++;
      if (bus.cko && !prev) begin
        bits[rises] = bus.dout;
        if (rises == 0) first_edge = edges;
        else chk("cko_period", edges - last_edge, 4);
        last_edge = edges;
        rises++;
      end
      if (bus2.cko && !prev2 && rises2 < 300) begin
        bits2[rises2] = bus2.dout;
        if (rises2 > 0) chk("cko2_period", edges - last_edge2, 6);
        last_edge2 = edges;
        rises2++;
      end
      prev = bus.cko;
      prev2 = bus2.cko;
    end
    chk("prbs_rises", rises, 254);
    chk("first_rise_edge", first_edge, 2);
    for (int n = 0; n < 254; n++) chk($sformatf("prbs%0d", n), bits[n], exp_bits[n]);
    ones = 0;
    diffs = 0;
    for (int n = 0; n < 127; n++) begin
      if (bits[n]) ones++;
      if (bits[n] !== bits[n+127]) diffs++;
    end
    chk("prbs_ones", ones, 64);
    chk("prbs_repeat_diffs", diffs, 0);
    chk("seed0_rises", rises2, 169);
    for (int n = 0; n < rises2; n++) chk($sformatf("seed0_%0d", n), bits2[n], exp_bits[n]);

    // ---- alternating mode from reset ----
    do_reset(1'b1);
    rises = 0; edges = 0; prev = 1'b0;
    while (rises < 8 && edges < 64) begin
      edge_s();
      edges++;
      if (bus.cko && !prev) begin
        chk($sformatf("alt%0d", rises), bus.dout, (rises % 2 == 0) ? 1'b1 : 1'b0);
        rises++;
      end
      prev = bus.cko;
    end
    chk("alt_rises", rises, 8);

    // ---- enable freeze for 10 edges while cko is high ----
    // Last sample was the edge of a rise (8th rise, dout=0), cnt is 0.
    d_hold = bus.dout;
    chk("freeze_start_dout", d_hold, 1'b0);
    edge_s();
    chk("freeze_pre_cko", bus.cko, 1'b1);
    set_in(1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      edge_s();
      chk($sformatf("freeze%0d_cko", i), bus.cko, 1'b1);
      chk($sformatf("freeze%0d_dout", i), bus.dout, 1'b0);
    end
    set_in(1'b1, 1'b1);
    edge_s();
    chk("resume_fall_cko", bus.cko, 1'b0);
    chk("resume_fall_dout", bus.dout, 1'b0);
    edge_s();
    edge_s();
    chk("resume_rise_cko", bus.cko, 1'b1);
    chk("resume_rise_dout", bus.dout, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
